// File: rtl/adc_serial_responder_if.sv
// Handshake and serial-line bundle for adc_serial_responder.
// master = local word source plus link receiver, slave = the responder.
interface adc_serial_responder_if #(
    parameter int WIDTH = 12
);
    logic             rc_in;
    logic [WIDTH-1:0] word_in;
    logic             word_valid;
    logic             word_ready;
    logic             data_out;
    logic             busy;
    logic             frame_done;
    logic             stale;
    logic             stale_clr;
    logic [1:0]       dbg_state;

    // word_in transfers on any edge where word_valid && word_ready; word_ready is high only
    // while the one-deep holding register is empty, and word_in/word_valid are held until then.
    modport master (
        output rc_in, word_in, word_valid, stale_clr,
        input  word_ready, data_out, busy, frame_done, stale, dbg_state
    );

    modport slave (
        input  rc_in, word_in, word_valid, stale_clr,
        output word_ready, data_out, busy, frame_done, stale, dbg_state
    );
endinterface

// File: rtl/adc_serial_responder.sv
// ADC stand-in for the ADS7808-style serial read link: each R/C rising edge sends one
// WIDTH-bit word MSB first on data_out, optionally inverted for the board buffers.
module adc_serial_responder #(
    parameter int WIDTH       = 12,
    parameter int SYNC_CYCLES = 2,
    parameter bit INVERT      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    adc_serial_responder_if.slave bus
);
    localparam int BW = $clog2(WIDTH) + 1;
    localparam int SW = $clog2(SYNC_CYCLES) + 1;
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_CYCLES - 1);
    localparam logic          IDLE_LVL  = INVERT;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SYNC  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_rc;
    logic             r_hold_full;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] r_last;
    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]    r_bit;
    logic [SW-1:0]    r_sync;
    logic             r_data;
    logic             r_done;
    logic             r_stale;

    logic w_req;
    logic w_start;
    logic w_sync_end;
    logic w_shifting;
    logic w_shift_end;

    // A request is rc_in seen low on one edge and high on the next; held-high rc_in never retriggers.
    assign w_req       = bus.rc_in & ~r_rc;
    assign w_start     = (r_state == S_IDLE) & w_req;
    assign w_sync_end  = (r_state == S_SYNC) & (r_sync == SYNC_LAST);
    assign w_shift_end = (r_state == S_SHIFT) & (r_bit == BIT_LAST);
    assign w_shifting  = w_sync_end | ((r_state == S_SHIFT) & ~w_shift_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req)       w_next = S_SYNC;
            S_SYNC:  if (w_sync_end)  w_next = S_SHIFT;
            S_SHIFT: if (w_shift_end) w_next = S_IDLE;
            default:                  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = (r_state != S_IDLE);
        bus.word_ready = ~r_hold_full;
        bus.data_out   = r_data;
        bus.frame_done = r_done;
        bus.stale      = r_stale;
        bus.dbg_state  = r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rc        <= 1'b0;
            r_hold_full <= 1'b0;
            r_hold      <= '0;
            r_last      <= '0;
            r_shift     <= '0;
            r_bit       <= '0;
            r_sync      <= '0;
            r_data      <= IDLE_LVL;
            r_done      <= 1'b0;
            r_stale     <= 1'b0;
        end else begin
            r_rc   <= bus.rc_in;
            r_done <= w_shift_end;

            // A frame start with an empty holding register leaves it free to load on the same edge.
            if (w_start && r_hold_full) begin
                r_last      <= r_hold;
                r_hold_full <= 1'b0;
            end else if (bus.word_valid && !r_hold_full) begin
                r_hold      <= bus.word_in;
                r_hold_full <= 1'b1;
            end

            if (w_start) begin
                r_shift <= r_hold_full ? r_hold : r_last;
            end else if (w_shifting) begin
                r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            end

            r_data <= w_shifting ? (r_shift[WIDTH-1] ^ INVERT) : IDLE_LVL;

            if (w_start) begin
                r_sync <= '0;
            end else if ((r_state == S_SYNC) && !w_sync_end) begin
                r_sync <= r_sync + SW'(1);
            end

            if (w_sync_end) begin
                r_bit <= '0;
            end else if (w_shifting) begin
                r_bit <= r_bit + BW'(1);
            end

            // Set wins over a simultaneous clear so a starved frame is never lost.
            if (w_start && !r_hold_full) begin
                r_stale <= 1'b1;
            end else if (bus.stale_clr) begin
                r_stale <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed bench for adc_serial_responder: drivers push expected words, a negedge monitor
// deserialises each frame from data_out and compares against the expected queue.
module tb_adc_serial_responder;
    localparam int WIDTH = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    adc_serial_responder_if #(.WIDTH(WIDTH)) bus ();

    adc_serial_responder #(
        .WIDTH      (WIDTH),
        .SYNC_CYCLES(2),
        .INVERT     (1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int frames_exp = 0;
    int frames_seen = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_hold = '0;
    logic [WIDTH-1:0] m_last = '0;
    bit               m_full = 1'b0;
    bit               m_stale = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_start();
        if (m_full) begin
            exp_q.push_back(m_hold);
            m_last = m_hold;
            m_full = 1'b0;
        end else begin
            exp_q.push_back(m_last);
            m_stale = 1'b1;
        end
        frames_exp++;
    endtask

    task automatic load_word(input logic [WIDTH-1:0] w);
        bus.word_in    = w;
        bus.word_valid = 1'b1;
        tick();
        bus.word_valid = 1'b0;
        m_hold = w;
        m_full = 1'b1;
        check("word_ready_after_load", bus.word_ready, 0);
    endtask

    task automatic request(input bit clr);
        bus.rc_in     = 1'b1;
        bus.stale_clr = clr;
        tick();
        bus.rc_in     = 1'b0;
        bus.stale_clr = 1'b0;
        model_start();
    endtask

    task automatic clear_stale();
        bus.stale_clr = 1'b1;
        tick();
        bus.stale_clr = 1'b0;
        m_stale = 1'b0;
        check("stale_after_clr", bus.stale, m_stale);
    endtask

    task automatic wait_done();
        int k = 0;
        while (k < 40) begin
            @(negedge clk);
            if (bus.frame_done) break;
            k++;
        end
        check("frame_done_within_budget", (k < 40), 1);
        tick();
    endtask

    // Monitor: busy first seen = n 0; idle level for n 0..1, bits MSB first at n 2..13, done at n 14.
    int               mon_n = 0;
    bit               mon_active = 1'b0;
    logic [WIDTH-1:0] mon_word = '0;
    logic [WIDTH-1:0] mon_exp;

    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (bus.busy) begin
                mon_active = 1'b1;
                mon_n = 0;
                mon_word = '0;
                check("sync_idle_level", bus.data_out, 1);
            end else begin
                check("no_stray_frame_done", bus.frame_done, 0);
            end
        end else begin
            mon_n++;
            if (mon_n < 2) begin
                check("sync_idle_level", bus.data_out, 1);
                check("busy_in_sync", bus.busy, 1);
            end else if (mon_n < 14) begin
                mon_word = {mon_word[WIDTH-2:0], ~bus.data_out};
                check("busy_in_shift", bus.busy, 1);
            end else begin
                check("frame_done_pulse", bus.frame_done, 1);
                check("busy_low_at_done", bus.busy, 0);
                check("idle_level_at_done", bus.data_out, 1);
                frames_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_frame: got %0h, expected no frame", mon_word);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("frame_word", mon_word, mon_exp);
                end
                mon_active = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rc_in      = 1'b0;
        bus.word_in    = '0;
        bus.word_valid = 1'b0;
        bus.stale_clr  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("reset_word_ready", bus.word_ready, 1);
        check("reset_data_out", bus.data_out, 1);
        check("reset_busy", bus.busy, 0);
        check("reset_stale", bus.stale, 0);
        check("reset_frame_done", bus.frame_done, 0);
        tick();

        // Request with nothing loaded: sends 0x000, flags stale
        request(1'b0);
        check("busy_after_start", bus.busy, 1);
        wait_done();
        check("stale_after_empty_frame", bus.stale, m_stale);

        // Directed 0xA5C frame
        load_word(12'hA5C);
        request(1'b0);
        check("word_ready_after_consume", bus.word_ready, 1);
        check("stale_held", bus.stale, m_stale);
        wait_done();
        clear_stale();

        // Loopback words
        load_word(12'hFFF); request(1'b0); wait_done();
        load_word(12'h001); request(1'b0); wait_done();
        load_word(12'h800); request(1'b0); wait_done();
        check("stale_fresh_words", bus.stale, m_stale);

        // Back-to-back: second request sampled on the edge ending the frame_done cycle
        load_word(12'h3C5);
        request(1'b0);
        load_word(12'h96A);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.frame_done) break;
        end
        bus.rc_in = 1'b1;
        tick();
        bus.rc_in = 1'b0;
        model_start();
        check("busy_back_to_back", bus.busy, 1);
        wait_done();

        // Request during SHIFT is dropped
        load_word(12'h4D2);
        request(1'b0);
        repeat (6) tick();
        check("state_shift", bus.dbg_state, 2);
        bus.rc_in = 1'b1;
        tick();
        bus.rc_in = 1'b0;
        wait_done();
        repeat (4) tick();

        // rc_in held high for 30 cycles gives a single frame
        load_word(12'h5A3);
        bus.rc_in = 1'b1;
        tick();
        model_start();
        repeat (29) tick();
        bus.rc_in = 1'b0;
        repeat (5) tick();
        check("frames_after_hold", frames_seen, frames_exp);

        // Reset while bit 5 is on the line, with a word waiting in the holding register
        load_word(12'h6B7);
        request(1'b0);
        load_word(12'h111);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(exp_q.pop_back());
        frames_exp--;
        m_full = 1'b0;
        m_last = '0;
        m_stale = 1'b0;
        check("abort_data_out", bus.data_out, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_word_ready", bus.word_ready, 1);
        check("abort_frame_done", bus.frame_done, 0);
        check("abort_stale", bus.stale, m_stale);
        tick();
        request(1'b0);
        check("stale_after_abort_request", bus.stale, m_stale);
        wait_done();

        // stale_clr on the same edge as a stale-setting start: set wins
        clear_stale();
        request(1'b1);
        check("stale_set_beats_clr", bus.stale, m_stale);
        wait_done();
        clear_stale();

        repeat (5) tick();
        check("frames_total", frames_seen, frames_exp);
        check("exp_queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/adc_serial_responder.md
Name: adc_serial_responder

Overview:
- Drives the far end of the ADS7808-style serial read link: answers an R/C request by shifting out one WIDTH-bit word on a single data line, MSB first, with the line-inversion convention our receiver undoes.
- Used as an ADC stand-in for board-to-board links between FPGAs, and as a loopback source on the ADC read path.
- Words come from local logic through a one-deep valid/ready holding register. Each R/C request consumes one word.

Parameters:
- WIDTH, 12, bits per frame.
- SYNC_CYCLES, 2, clk edges between request detection and the first data bit, minimum 1.
- INVERT, 1, when 1 the line carries ~bit, matching the board transceiver/buffer inversion.

Ports:
- clk  input  1  system clock. The same clock is passed to the peer as its adc clock.
- rst  input  1  synchronous reset, active-high.
- rc_in  input  1  R/C request from the receiver. Active level high as seen on the FPGA pin. Synchronous to clk.
- word_in  input  WIDTH  next word to send.
- word_valid  input  1  word_in is valid.
- word_ready  output  1  holding register is empty and can accept a word.
- data_out  output  1  serial data line (registered).
- busy  output  1  a frame is in progress (SYNC or SHIFT state).
- frame_done  output  1  single-cycle pulse after the last bit of a frame.
- stale  output  1  sticky flag: a frame was sent with no fresh word available.
- stale_clr  input  1  clears stale.

Behaviour:
- Reset: state IDLE, holding register empty, last-word register 0, shift register 0, counters 0.
  - Outputs: word_ready=1, busy=0, frame_done=0, stale=0.
  - data_out is at the idle level: logical 0, driven as 1 when INVERT=1.
- Holding register:
  - It loads when word_valid && word_ready.
  - word_ready = holding register empty. It deasserts the cycle after a load and reasserts the cycle after the holding register is consumed.
  - A load and a consume in the same cycle are not possible, because word_ready=0 while the register is full.
- Request detection:
  - rc_in is registered once. A request is a rising edge of the registered rc_in, i.e. rc_in low then high on consecutive edges.
  - If rc_in is held high, only the first edge triggers a frame.
  - Edges seen while busy=1 are ignored; no queueing.
- State machine (IDLE, SYNC, SHIFT):
  - IDLE → SYNC, on the edge D where the request is detected:
    - If the holding register is full, its word moves into the shift register and the last-word register, and the holding register empties.
    - Otherwise the last-word register is reused and stale is set.
    - busy=1 from the cycle after D.
  - SYNC: count SYNC_CYCLES-1 further edges, with data_out at the idle level. Then → SHIFT.
  - SHIFT: data_out presents bit WIDTH-1-i (XOR INVERT), registered after edge D+SYNC_CYCLES+i, for i=0..WIDTH-1. That is one bit per clk, MSB first.
  - After the LSB has been held for one cycle, → IDLE. data_out returns to the idle level, frame_done pulses for exactly one cycle, and busy=0 in that same cycle.
- Timing with SYNC_CYCLES=2: the MSB is stable at edge D+3. This lines up with our receiver, which samples the MSB on the fourth edge after it raises R/C.
- Back-to-back frames:
  - A new request may be detected in the frame_done cycle; it starts the next frame with no gap.
  - A request detected during SHIFT is dropped.
- stale:
  - Set on any frame start that has no fresh word.
  - stale_clr clears it. If a set and a clear happen on the same edge, the set wins.
- Reset mid-frame aborts the frame immediately. No frame_done is generated, and the holding register is emptied.
- Width rules:
  - Bit index counter: ceil(log2(WIDTH))+1 bits.
  - Sync counter: sized for SYNC_CYCLES.
  - No arithmetic on data.

Test Plan:
- Reset then idle:
  - Required: word_ready=1, data_out=1 (INVERT=1), busy=0, stale=0.
  - Then rc_in pulses with no word loaded: the frame sends 0x000 as twelve 1s, stale=1, frame_done pulses once.
- Load 0xA5C, then pulse rc_in at edge D:
  - data_out stays 1 through D+2.
  - Sequence ~(1,0,1,0,0,1,0,1,1,1,0,0) appears after edges D+2..D+13.
  - frame_done at D+14, word_ready back to 1.
- Loopback: connect one adc_data instance as receiver, with enable held high, and feed words 0xFFF, 0x001, 0x800 in turn.
  - Required: the receiver's data_out equals each word in order, with no bit slip.
- Hold rc_in high for 30 cycles, and separately pulse rc_in again mid-SHIFT.
  - Required: exactly one frame in each case, the second request ignored, busy held continuously.
- Assert rst at bit 5 of a frame.
  - Next cycle: data_out=1, busy=0, word_ready=1, no frame_done.
  - A following request sends the last-word register with stale set.
- Drive stale_clr on the same edge as a stale-setting frame start.
  - Required: stale=1. An isolated stale_clr then gives stale=0.
